aes_key_sched_ctrl: RTL and testbench

Sequencer for AES-128 key expansion. It accepts a 128-bit cipher key, drives one shared g-function instance with the last key word and the round number, and produces round keys 0..10 in order on a valid/ready stream. It sits between the key-load interface and the round datapath, and replaces any per-round key logic.

---
 rtl/aes_pkg.sv | 18 +
 rtl/aes_key_sched_ctrl_g.sv | 69 ++++++
 rtl/aes_key_sched_ctrl.sv | 140 ++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 key schedule sequencer.
//   state_t       : sequencer states (FILL only reachable with AES_KEY_SCHED_REVERSE_EN)
//   AES128_ROUNDS : last round index of the AES-128 schedule
//   rnd_t, word_t : round index and 32-bit key word types
package aes_pkg;

    localparam int AES128_ROUNDS = 10;

    typedef logic [3:0]  rnd_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2
    } state_t;

endpackage

// File: rtl/aes_key_sched_ctrl_g.sv
// AES key-expansion g function: t = SubWord(RotWord(w)) ^ {Rcon(rnd), 24'h0}.
// Ports:
//   w   in  32  last word of the current round key
//   rnd in  4   round number being generated (1..10)
//   t   out 32  g result
module aes_key_sched_ctrl_g
    import aes_pkg::*;
(
    input  word_t w,
    input  rnd_t  rnd,
    output word_t t
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from first principles: inverse is a^254 = prod a^(2^k), k=1..7,
    // which also maps 0 to 0 as the S-box requires; then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] b;
        sq = a;
        b  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            b  = gf_mul(b, sq);
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
               {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    logic [7:0] rcon;
    always_comb begin
        rcon = 8'h00;
        case (rnd)
            4'd1:  rcon = 8'h01;
            4'd2:  rcon = 8'h02;
            4'd3:  rcon = 8'h04;
            4'd4:  rcon = 8'h08;
            4'd5:  rcon = 8'h10;
            4'd6:  rcon = 8'h20;
            4'd7:  rcon = 8'h40;
            4'd8:  rcon = 8'h80;
            4'd9:  rcon = 8'h1b;
            4'd10: rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    word_t rot;
    word_t sub;
    assign rot = {w[23:0], w[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        assign sub[8*i +: 8] = sbox(rot[8*i +: 8]);
    end

    assign t = sub ^ {rcon, 24'h000000};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule sequencer. Takes a cipher key and streams round keys
// 0..10 on a valid/ready interface using one shared g-function instance.
// Optional macro AES_KEY_SCHED_REVERSE_EN: rev_i=1 at key acceptance first
// fills an 11-entry key buffer, then emits rounds 10 down to 0.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   key_valid/key_ready key load handshake; key_in = {w0,w1,w2,w3}
//   rev_i               descending order select (macro builds only)
//   abort               synchronous flush to IDLE, highest priority
//   rk_valid/rk_ready   round key handshake; rk_data, rk_round
//   done                one-cycle pulse after the final round key handshake
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS,
    parameter int KEY_W      = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [KEY_W-1:0] key_in,
    input  logic             rev_i,
    input  logic             abort,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [KEY_W-1:0] rk_data,
    output logic [3:0]       rk_round,
    output logic             done
);

    localparam rnd_t LAST = rnd_t'(NUM_ROUNDS);

    state_t           state;
    logic [KEY_W-1:0] wkey;
    logic [KEY_W-1:0] nkey;
    rnd_t             cnt;
    rnd_t             g_rnd;
    word_t            t;
    word_t            w0n, w1n, w2n, w3n;
    logic             rev_mode;

    assign key_ready = (state == IDLE);
    assign rk_valid  = (state == EMIT);
    assign rk_round  = rk_valid ? cnt : '0;

    // Saturate so g only ever sees 1..10, even while the counter sits at 10.
    assign g_rnd = (cnt < LAST) ? cnt + rnd_t'(1) : LAST;

    aes_key_sched_ctrl_g u_g (
        .w   (wkey[31:0]),
        .rnd (g_rnd),
        .t   (t)
    );

    assign w0n  = wkey[127:96] ^ t;
    assign w1n  = wkey[95:64]  ^ w0n;
    assign w2n  = wkey[63:32]  ^ w1n;
    assign w3n  = wkey[31:0]   ^ w2n;
    assign nkey = {w0n, w1n, w2n, w3n};

`ifdef AES_KEY_SCHED_REVERSE_EN
    logic             rev;
    logic [KEY_W-1:0] kbuf [0:NUM_ROUNDS];

    assign rev_mode = rev;

    // Buffer needs no reset: it is fully rewritten in FILL before any read.
    always_ff @(posedge clk) begin
        if (state == FILL) kbuf[cnt] <= wkey;
    end

    assign rk_data = rk_valid ? (rev ? kbuf[cnt] : wkey) : '0;
`else
    logic unused_rev;
    assign unused_rev = rev_i;
    assign rev_mode   = 1'b0;
    assign rk_data    = rk_valid ? wkey : '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            wkey  <= '0;
            cnt   <= '0;
            done  <= 1'b0;
`ifdef AES_KEY_SCHED_REVERSE_EN
            rev   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: if (key_valid) begin
                        wkey  <= key_in;
                        cnt   <= '0;
                        state <= EMIT;
`ifdef AES_KEY_SCHED_REVERSE_EN
                        rev   <= rev_i;
                        if (rev_i) state <= FILL;
`endif
                    end
`ifdef AES_KEY_SCHED_REVERSE_EN
                    // Round cnt is stored this cycle; counter stays at 10 for EMIT.
                    FILL: begin
                        if (cnt == LAST) begin
                            state <= EMIT;
                        end else begin
                            wkey <= nkey;
                            cnt  <= cnt + rnd_t'(1);
                        end
                    end
`endif
                    EMIT: if (rk_ready) begin
                        if (rev_mode) begin
                            if (cnt == '0) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end else begin
                                cnt <= cnt - rnd_t'(1);
                            end
                        end else if (cnt == LAST) begin
                            state <= IDLE;
                            done  <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            wkey <= nkey;
                            cnt  <= cnt + rnd_t'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Scoreboard bench for aes_key_sched_ctrl. Honours AES_KEY_SCHED_REVERSE_EN.
module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         key_valid = 1'b0;
    logic [127:0] key_in = '0;
    logic         rev_i = 1'b0;
    logic         abort = 1'b0;
    logic         rk_ready = 1'b1;
    logic         key_ready;
    logic         rk_valid;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         done;

    always #5 clk = ~clk;

    aes_key_sched_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
        .rev_i     (rev_i),
        .abort     (abort),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_data   (rk_data),
        .rk_round  (rk_round),
        .done      (done)
    );

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned cyc = 0;
    int acc_cnt = 0;
    int b2b_target = -1;
    bit rdy_rand = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sb [256];

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
        return (v << s) | (v >> (8 - s));
    endfunction

    // Classic generator walk: p steps by x3, q by its inverse.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] model_rk(input logic [127:0] key, input int r);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ tmp;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    typedef struct {
        logic [127:0] key;
        logic [3:0]   rnd;
        logic [127:0] data;
        bit           last;
    } exp_t;

    exp_t q[$];
    exp_t e;

    // ---------------- monitor / scoreboard ----------------
    bit           stall_prev = 1'b0;
    logic [127:0] hold_d;
    logic [3:0]   hold_r;
    bit           done_due = 1'b0;
    bit           first_pending = 1'b0;
    int unsigned  acc_edge = 0;
    int unsigned  fin_edge = 0;
    int unsigned  exp_lat = 0;
    bit           rev_eff;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            stall_prev    = 1'b0;
            done_due      = 1'b0;
            first_pending = 1'b0;
        end else begin
            chk("done", {127'b0, done}, {127'b0, done_due});
            if (done_due) chk("key_ready_at_done", {127'b0, key_ready}, 128'd1);
            done_due = 1'b0;
            if (stall_prev) begin
                chk("hold_valid", {127'b0, rk_valid}, 128'd1);
                chk("hold_data", rk_data, hold_d);
                chk("hold_round", {124'b0, rk_round}, {124'b0, hold_r});
            end
            stall_prev = 1'b0;
            if (abort) begin
                q.delete();
                first_pending = 1'b0;
            end else begin
                if (rk_valid && first_pending) begin
                    chk("first_rk_latency", 128'(cyc - acc_edge), 128'(exp_lat));
                    first_pending = 1'b0;
                end
                if (rk_valid && rk_ready) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_rk: round %0d data %h, nothing expected", rk_round, rk_data);
                    end else begin
                        e = q.pop_front();
                        chk("rk_round", {124'b0, rk_round}, {124'b0, e.rnd});
                        chk("rk_data", rk_data, e.data);
                        if (e.key == FIPS_KEY && e.rnd == 4'd1)
                            chk("fips_round1", rk_data, 128'ha0fafe1788542cb123a339392a6c7605);
                        if (e.key == FIPS_KEY && e.rnd == 4'd10)
                            chk("fips_round10", rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
                        if (e.key == FIPS_KEY && e.rnd == 4'd0)
                            chk("fips_round0", rk_data, FIPS_KEY);
                        if (e.key == SEQ_KEY && e.rnd == 4'd10)
                            chk("seq_round10", rk_data, 128'h13111d7fe3944a17f307a78b4d2b30c5);
                        if (e.last) begin
                            done_due = 1'b1;
                            fin_edge = cyc + 1;
                        end
                    end
                end else if (rk_valid) begin
                    stall_prev = 1'b1;
                    hold_d     = rk_data;
                    hold_r     = rk_round;
                end
                if (key_valid && key_ready) begin
                    acc_cnt++;
                    if (acc_cnt == b2b_target)
                        chk("b2b_accept_edge", 128'(cyc + 1), 128'(fin_edge + 1));
`ifdef AES_KEY_SCHED_REVERSE_EN
                    rev_eff = rev_i;
`else
                    rev_eff = 1'b0;
`endif
                    for (int i = 0; i <= 10; i++) begin
                        e.key  = key_in;
                        e.rnd  = rev_eff ? 4'(10 - i) : 4'(i);
                        e.data = model_rk(key_in, int'(e.rnd));
                        e.last = (i == 10);
                        q.push_back(e);
                    end
                    first_pending = 1'b1;
                    acc_edge      = cyc + 1;
                    exp_lat       = rev_eff ? 11 : 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        rk_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_key(input logic [127:0] k, input logic rv);
        int n;
        bit acc;
        key_in    = k;
        rev_i     = rv;
        key_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = key_ready && !abort;
            tick();
            n++;
        end while (!acc && n < 50);
        key_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL key_accept_timeout: got no accept want accept within 50 cycles");
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(q.size() == 0 && key_ready) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_timeout: got %0d pending want 0", q.size());
        end
        tick();
        tick();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_key_ready"}, {127'b0, key_ready}, 128'd1);
        chk({tag, "_rk_valid"}, {127'b0, rk_valid}, 128'd0);
        chk({tag, "_rk_data"}, rk_data, 128'd0);
        chk({tag, "_rk_round"}, {124'b0, rk_round}, 128'd0);
        chk({tag, "_done"}, {127'b0, done}, 128'd0);
    endtask

    initial begin
        int n;
        build_sbox();
        #1 rst_n = 1'b0;
        #1 chk_reset_outs("por");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // FIPS key, always ready
        send_key(FIPS_KEY, 1'b0);
        wait_idle();

        // FIPS key, random backpressure
        rdy_rand = 1'b1;
        send_key(FIPS_KEY, 1'b0);
        wait_idle();
        rdy_rand = 1'b0;

        // abort while round 4 is presented
        send_key(FIPS_KEY, 1'b0);
        n = 0;
        while (!(rk_valid && rk_round == 4'd4) && n < 50) begin
            tick();
            n++;
        end
        chk("abort_reach_r4", {124'b0, rk_round}, 128'd4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_rk_valid", {127'b0, rk_valid}, 128'd0);
        chk("abort_key_ready", {127'b0, key_ready}, 128'd1);
        tick();
        send_key(SEQ_KEY, 1'b0);
        wait_idle();

        // reset mid-schedule, key offered during EMIT must be refused
        rdy_rand = 1'b1;
        send_key(SEQ_KEY, 1'b0);
        tick();
        key_in    = 128'hdeadbeef_00000000_cafef00d_12345678;
        key_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("emit_key_ready", {127'b0, key_ready}, 128'd0);
            tick();
        end
        key_valid = 1'b0;
        rst_n = 1'b0;
        #1 chk_reset_outs("mid_rst");
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        rdy_rand = 1'b0;
        tick();

        // key_valid held high across two schedules
        b2b_target = acc_cnt + 2;
        key_in     = FIPS_KEY;
        rev_i      = 1'b0;
        key_valid  = 1'b1;
        tick();
        key_in = SEQ_KEY;
        n = 0;
        while (acc_cnt < b2b_target && n < 100) begin
            tick();
            n++;
        end
        key_valid = 1'b0;
        if (acc_cnt < b2b_target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL b2b_second_accept: got %0d accepts want %0d", acc_cnt, b2b_target);
        end
        wait_idle();

`ifdef AES_KEY_SCHED_REVERSE_EN
        send_key(FIPS_KEY, 1'b1);
        wait_idle();
        rdy_rand = 1'b1;
        send_key(SEQ_KEY, 1'b1);
        wait_idle();
`endif

        // random keys, random order select, random backpressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_key({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
            wait_idle();
        end
        rdy_rand = 1'b0;

        chk("queue_drained", 128'(q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish want finish before 400000");
        $fatal(1, "watchdog");
    end

endmodule
